// File: rtl/spi_flash_reader_if.sv
// Bus bundle around spi_flash_reader.
// Groups three sets of signals:
//   request side : req_valid, req_ready, req_addr, req_len, done, err
//   byte stream  : out_valid, out_ready, out_data, out_last
//   iomem port   : sel, addr, wdata, wstrb, rdata
// Modports:
//   slave  - view taken by spi_flash_reader itself. It serves read requests
//            and drives the SPI controller's iomem port.
//   master - view taken by whatever surrounds the reader. That is the
//            requester, the stream consumer and the SPI controller.
interface spi_flash_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [15:0] req_len;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        done;
  logic        err;
  logic        sel;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport slave (
    input  req_valid, req_addr, req_len, out_ready, rdata,
    output req_ready, out_valid, out_data, out_last, done, err,
           sel, addr, wdata, wstrb
  );

  modport master (
    output req_valid, req_addr, req_len, out_ready, rdata,
    input  req_ready, out_valid, out_data, out_last, done, err,
           sel, addr, wdata, wstrb
  );
endinterface

// File: rtl/spi_flash_reader.sv
// spi_flash_reader
// This block is the sequencer that sits in front of the SPI iomem controller.
// It reads from flash in the following order:
//   1. Accept one request (a 24-bit address and a byte count).
//   2. Shift out the READ opcode and the three address bytes.
//   3. Shift out one dummy byte per data byte.
//   4. Return each received byte on a valid/ready stream that holds one byte.
//
// Ports:
//   clk    system clock
//   reset  asynchronous reset, active low
//   bus    spi_flash_reader_if.slave
//            req_*  request handshake
//            done   completion pulse
//            err    sticky timeout flag
//            out_*  received byte stream
//            sel/addr/wdata/wstrb/rdata  iomem port of the SPI controller
//
// States:
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | ready for a request
//   S_ISSUE  | one-cycle iomem write of the current tx byte
//   S_WAIT   | settle delay before busy is trusted
//   S_POLL   | sample busy; count toward the timeout
//   S_OUT    | received data byte held on the stream until it is accepted
//   S_FINISH | one-cycle done pulse
module spi_flash_reader #(
  parameter logic [7:0] CMD_READ   = 8'h03,
  parameter logic [7:0] CTRL_MID   = 8'h12,
  parameter logic [7:0] CTRL_END   = 8'h92,
  parameter int         BUSY_BIT   = 31,
  parameter int         POLL_DELAY = 2,
  parameter int         TIMEOUT    = 1024
) (
  input logic           clk,
  input logic           reset,
  spi_flash_reader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_POLL,
    S_OUT,
    S_FINISH
  } state_t;

  // Both timers count down and end on a terminal-count compare.
  // The wait timer is loaded with POLL_DELAY-1, so S_WAIT lasts exactly
  // POLL_DELAY cycles.
  localparam int WW = (POLL_DELAY > 1) ? $clog2(POLL_DELAY) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(POLL_DELAY - 1);
  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT);

  state_t        state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [15:0]   remain_q, remain_d;
  logic [23:0]   addr_q, addr_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    data_q, data_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic          to_pulse_q, to_pulse_d;

  logic [7:0]    tx_byte;
  logic [7:0]    ctrl;
  logic          busy;
  logic          unused_rdata;

  assign busy         = bus.rdata[BUSY_BIT];
  assign unused_rdata = ^bus.rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      phase_q    <= 3'd0;
      remain_q   <= 16'd0;
      addr_q     <= 24'd0;
      wait_q     <= '0;
      to_q       <= '0;
      data_q     <= 8'd0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      to_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      remain_q   <= remain_d;
      addr_q     <= addr_d;
      wait_q     <= wait_d;
      to_q       <= to_d;
      data_q     <= data_d;
      last_q     <= last_d;
      err_q      <= err_d;
      to_pulse_q <= to_pulse_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    remain_d   = remain_q;
    addr_d     = addr_q;
    wait_d     = wait_q;
    to_d       = to_q;
    data_d     = data_q;
    last_d     = last_q;
    err_d      = err_q;
    to_pulse_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          remain_d = bus.req_len;
          phase_d  = 3'd0;
          err_d    = 1'b0;
          state_d  = (bus.req_len == 16'd0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_d  = WAIT_LOAD;
        to_d    = TO_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_POLL;
        else              wait_d  = wait_q - 1'b1;
      end
      S_POLL: begin
        if (busy) begin
          // The timeout abandons the request. The state of chip select is
          // left for the caller to sort out.
          if (to_q == TW'(1)) begin
            err_d      = 1'b1;
            to_pulse_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            to_d = to_q - 1'b1;
          end
        end else if (phase_q != 3'd4) begin
          phase_d = phase_q + 3'd1;
          state_d = S_ISSUE;
        end else begin
          data_d  = bus.rdata[7:0];
          last_d  = (remain_q == 16'd1);
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          remain_d = remain_q - 16'd1;
          state_d  = (remain_q == 16'd1) ? S_FINISH : S_ISSUE;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (phase_q)
      3'd0:    tx_byte = CMD_READ;
      3'd1:    tx_byte = addr_q[23:16];
      3'd2:    tx_byte = addr_q[15:8];
      3'd3:    tx_byte = addr_q[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  // Chip select is released only after the dummy byte of the last data byte.
  assign ctrl = (phase_q == 3'd4 && remain_q == 16'd1) ? CTRL_END : CTRL_MID;

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.sel       = (state_q == S_ISSUE);
  assign bus.addr      = 8'h00;
  assign bus.wdata     = (state_q == S_ISSUE) ? {16'h0000, ctrl, tx_byte} : 32'h0;
  assign bus.wstrb     = (state_q == S_ISSUE) ? 4'b0011 : 4'b0000;
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_data  = data_q;
  assign bus.out_last  = (state_q == S_OUT) && last_q;
  assign bus.done      = (state_q == S_FINISH) || to_pulse_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
module tb_spi_flash_reader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_flash_reader_if bus_if();

  spi_flash_reader #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_wr[$];
  logic [8:0]  exp_out[$];
  logic        exp_done[$];
  logic [7:0]  rx_q[$];

  int       wr_cnt = 0;
  int       busy_cnt = 0;
  bit       hold_busy = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  int       sel_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected event, value %h with nothing expected", name, act);
  endtask

  // Monitor and scoreboard. These compare whatever the DUT presents
  // against the queued expectations.
  initial forever begin
    @(negedge clk);
    if (bus_if.sel === 1'b1) begin
      sel_cyc = cyc;
      if (exp_wr.size() == 0) unexpected("wr_wdata", bus_if.wdata);
      else begin
        chk("wr_wdata", bus_if.wdata, exp_wr.pop_front());
        chk("wr_wstrb", 32'(bus_if.wstrb), 32'h3);
        chk("wr_addr", 32'(bus_if.addr), 32'h0);
      end
    end
    if (bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
      if (exp_out.size() == 0) unexpected("out_byte", 32'({bus_if.out_last, bus_if.out_data}));
      else chk("out_byte", 32'({bus_if.out_last, bus_if.out_data}), 32'(exp_out.pop_front()));
    end
    if (bus_if.done === 1'b1) begin
      if (exp_done.size() == 0) unexpected("done_err", 32'(bus_if.err));
      else chk("done_err", 32'(bus_if.err), 32'(exp_done.pop_front()));
    end
  end

  // SPI controller model. Each write makes busy read 1 for three cycles.
  // The fifth and later writes of a request are data bytes, and each one
  // returns the next byte from rx_q. While busy, [7:0] reads back as FF.
  initial forever begin
    @(negedge clk);
    if (bus_if.sel === 1'b1) begin
      wr_cnt++;
      if (wr_cnt >= 5) rx_byte = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hEE;
      busy_cnt = 3;
      bus_if.rdata = 32'h8000_00FF;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) bus_if.rdata = {24'h0, rx_byte};
    end
    if (hold_busy) bus_if.rdata[31] = 1'b1;
  end

  task automatic run_req(input logic [23:0] a, input logic [15:0] len);
    bit acc = 1'b0;
    @(posedge clk); #1;
    wr_cnt = 0;
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = a;
    bus_if.req_len   = len;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus_if.req_ready;
    end
    if (!acc) unexpected("req_accept_timeout", 32'(len));
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = bus_if.done;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_wait: no done pulse within %0d cycles", budget);
    end
  endtask

  task automatic push_wr4(input logic [23:0] a);
    exp_wr.push_back(32'h0000_1203);
    exp_wr.push_back({16'h0, 8'h12, a[23:16]});
    exp_wr.push_back({16'h0, 8'h12, a[15:8]});
    exp_wr.push_back({16'h0, 8'h12, a[7:0]});
  endtask

  initial begin
    int bad, sels;
    bit seen;
    bus_if.req_valid = 1'b0;
    bus_if.req_addr  = 24'h0;
    bus_if.req_len   = 16'h0;
    bus_if.out_ready = 1'b1;
    bus_if.rdata     = 32'h0;
    reset = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sel", 32'(bus_if.sel), 0);
    chk("rst_out_valid", 32'(bus_if.out_valid), 0);
    chk("rst_out_last", 32'(bus_if.out_last), 0);
    chk("rst_done", 32'(bus_if.done), 0);
    chk("rst_err", 32'(bus_if.err), 0);
    chk("rst_wdata", bus_if.wdata, 0);
    chk("rst_wstrb", 32'(bus_if.wstrb), 0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(bus_if.req_ready), 1);

    // Basic two-byte read
    exp_wr.push_back(32'h1203); exp_wr.push_back(32'h1212);
    exp_wr.push_back(32'h1234); exp_wr.push_back(32'h1256);
    exp_wr.push_back(32'h1200); exp_wr.push_back(32'h9200);
    rx_q.push_back(8'hDE); rx_q.push_back(8'hAD);
    exp_out.push_back(9'h0DE); exp_out.push_back(9'h1AD);
    exp_done.push_back(1'b0);
    run_req(24'h123456, 16'd2);
    wait_done(200);

    // Backpressure on the first data byte
    push_wr4(24'h123456);
    exp_wr.push_back(32'h1200); exp_wr.push_back(32'h9200);
    rx_q.push_back(8'hDE); rx_q.push_back(8'hAD);
    exp_out.push_back(9'h0DE); exp_out.push_back(9'h1AD);
    exp_done.push_back(1'b0);
    bus_if.out_ready = 1'b0;
    run_req(24'h123456, 16'd2);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = bus_if.out_valid;
    end
    chk("bp_out_valid_seen", 32'(seen), 1);
    bad = 0; sels = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 8'hDE || bus_if.out_last !== 1'b0) bad++;
      if (bus_if.sel === 1'b1) sels++;
    end
    chk("bp_hold_stable", 32'(bad), 0);
    chk("bp_no_sel", 32'(sels), 0);
    @(posedge clk); #1 bus_if.out_ready = 1'b1;
    wait_done(200);

    // Zero-length request
    exp_done.push_back(1'b0);
    run_req(24'h00ABCD, 16'd0);
    wait_done(2);

    // Timeout while polling the command byte
    hold_busy = 1'b1;
    exp_wr.push_back(32'h1203);
    exp_done.push_back(1'b1);
    run_req(24'h000010, 16'd4);
    wait_done(100);
    chk("to_cycles", 32'(cyc - sel_cyc), 32'd19);
    @(negedge clk);
    chk("to_err_sticky", 32'(bus_if.err), 1);
    chk("to_idle", 32'(bus_if.req_ready), 1);
    hold_busy = 1'b0;

    // The next request clears err, and its one byte is also the last byte.
    push_wr4(24'hABCDEF);
    exp_wr.push_back(32'h9200);
    rx_q.push_back(8'h5A);
    exp_out.push_back(9'h15A);
    exp_done.push_back(1'b0);
    run_req(24'hABCDEF, 16'd1);
    @(negedge clk);
    chk("err_cleared", 32'(bus_if.err), 0);
    wait_done(200);

    // Reset while polling the first address byte
    exp_wr.push_back(32'h1203); exp_wr.push_back(32'h1212);
    run_req(24'h123456, 16'd3);
    for (int i = 0; i < 100 && wr_cnt < 2; i++) @(negedge clk);
    chk("mid_wr_cnt", 32'(wr_cnt), 2);
    hold_busy = 1'b1;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mid_sel", 32'(bus_if.sel), 0);
    chk("mid_wdata", bus_if.wdata, 0);
    chk("mid_done", 32'(bus_if.done), 0);
    chk("mid_out_valid", 32'(bus_if.out_valid), 0);
    chk("mid_req_ready", 32'(bus_if.req_ready), 1);
    exp_wr.delete(); exp_out.delete(); exp_done.delete(); rx_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    hold_busy = 1'b0;
    push_wr4(24'h123456);
    exp_wr.push_back(32'h9200);
    rx_q.push_back(8'hC3);
    exp_out.push_back(9'h1C3);
    exp_done.push_back(1'b0);
    run_req(24'h123456, 16'd1);
    wait_done(200);

    repeat (3) @(negedge clk);
    chk("left_wr", 32'(exp_wr.size()), 0);
    chk("left_out", 32'(exp_out.size()), 0);
    chk("left_done", 32'(exp_done.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end
endmodule
